// File: rtl/comm_pkg.sv
// Shared definitions for the I/Q mapping framer: mode codes, FSM encoding,
// and a constant log2 helper used to size counters.
package comm_pkg;

  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // floor(log2(n)); exact for the power-of-two frame sizes used here
  function automatic int log2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= n) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_symbol_map.sv
// Combinational constellation mapper: BPSK uses bit0 on I only, QPSK uses
// bit0 on I and bit1 on Q. Each bit selects +AMP (1) or -AMP (0).
module iq_symbol_map
  import comm_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int AMP   = 256
) (
  input  logic                    mode_i,
  input  logic [1:0]              bits_i,
  output logic signed [WIDTH-1:0] xr_o,
  output logic signed [WIDTH-1:0] xi_o
);

  localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] NEG = WIDTH'(-AMP);

  // map the bit pair to signed I/Q levels; Q stays zero in BPSK
  always_comb begin
    xr_o = bits_i[0] ? POS : NEG;
    xi_o = '0;
    if (mode_i == MODE_QPSK) xi_o = bits_i[1] ? POS : NEG;
  end

endmodule

// File: rtl/comm_map_framer.sv
// Pops words from a FWFT FIFO, maps them LSB-first to BPSK/QPSK samples and
// emits gapless FFT_N-sample frames with sof/eof. Downstream ready is only
// consulted at frame boundaries so a frame is never split.
//
// state | meaning
// IDLE  | no word held, waiting for !empty && ready_i
// RUN   | emitting one sample per cycle
// HOLD  | between frames, waiting for ready_i (word may be partly consumed)
//
// The shift register LSBs always hold the most recently emitted sample, so the
// next sample comes either from din (load) or from the register shifted by one
// symbol. Output registers are fed from the next-state shift register to give
// one cycle load-to-sample latency.
module comm_map_framer
  import comm_pkg::*;
#(
  parameter int DIN_W = 128,
  parameter int FFT_N = 64,
  parameter int WIDTH = 11,
  parameter int AMP   = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    rd_en,
  input  logic [DIN_W-1:0]        din,
  input  logic                    empty,
  input  logic                    mode,
  input  logic                    ready_i,
  output logic signed [WIDTH-1:0] xr,
  output logic signed [WIDTH-1:0] xi,
  output logic                    valid_o,
  output logic                    sof,
  output logic                    eof,
  output logic                    busy
);

  localparam int CNT_W = (log2_int(FFT_N) < 1) ? 1 : log2_int(FFT_N);
  localparam int WL_W  = $clog2(DIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_N - 1);
  localparam logic [WL_W-1:0]  WL_BPSK  = WL_W'(DIN_W - 1);
  localparam logic [WL_W-1:0]  WL_QPSK  = WL_W'(DIN_W / 2 - 1);

  state_t                  state_q, state_d;
  logic [DIN_W-1:0]        shreg_q, shreg_d;
  logic                    mode_q, mode_d;
  logic [CNT_W-1:0]        samp_cnt_q, samp_cnt_d;
  logic [WL_W-1:0]         word_left_q, word_left_d;
  logic signed [WIDTH-1:0] xr_q, xr_d, xi_q, xi_d;
  logic signed [WIDTH-1:0] map_xr, map_xi;
  logic                    valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic                    word_done, at_eof, load, emit;

  assign word_done = (word_left_q == '0);
  assign at_eof    = valid_q && (samp_cnt_q == CNT_LAST);
  assign load      = !empty && ready_i &&
                     ((state_q == ST_IDLE) ||
                      (state_q == ST_HOLD && word_done) ||
                      (state_q == ST_RUN && at_eof && word_done));
  assign emit      = (state_d == ST_RUN);

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state: frame boundaries decide between continuing, holding and idling
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load) state_d = ST_RUN;
      ST_RUN: begin
        if (at_eof) begin
          if (!word_done)              state_d = ready_i ? ST_RUN : ST_HOLD;
          else if (load)               state_d = ST_RUN;
          else if (!ready_i && !empty) state_d = ST_HOLD;
          else                         state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!word_done) begin
          if (ready_i) state_d = ST_RUN;
        end else if (load) begin
          state_d = ST_RUN;
        end else if (ready_i && empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // word datapath next-state: capture on load, otherwise shift one symbol per emitted sample
  always_comb begin
    shreg_d     = shreg_q;
    mode_d      = mode_q;
    word_left_d = word_left_q;
    if (load) begin
      shreg_d     = din;
      mode_d      = mode;
      word_left_d = (mode == MODE_QPSK) ? WL_QPSK : WL_BPSK;
    end else if (emit) begin
      shreg_d     = (mode_q == MODE_QPSK) ? (shreg_q >> 2) : (shreg_q >> 1);
      word_left_d = word_left_q - 1'b1;
    end
  end

  iq_symbol_map #(
    .WIDTH (WIDTH),
    .AMP   (AMP)
  ) u_map (
    .mode_i (mode_d),
    .bits_i (shreg_d[1:0]),
    .xr_o   (map_xr),
    .xi_o   (map_xi)
  );

  // FSM outputs: rd_en plus next values of the registered sample/marker outputs
  always_comb begin
    rd_en      = load;
    valid_d    = emit;
    samp_cnt_d = samp_cnt_q;
    if (emit) samp_cnt_d = (valid_q && !at_eof) ? samp_cnt_q + 1'b1 : '0;
    sof_d      = emit && (samp_cnt_d == '0);
    eof_d      = emit && (samp_cnt_d == CNT_LAST);
    xr_d       = emit ? map_xr : '0;
    xi_d       = emit ? map_xi : '0;
  end

  // datapath and output registers; reset discards any held word
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q     <= '0;
      mode_q      <= MODE_BPSK;
      samp_cnt_q  <= '0;
      word_left_q <= '0;
      xr_q        <= '0;
      xi_q        <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      mode_q      <= mode_d;
      samp_cnt_q  <= samp_cnt_d;
      word_left_q <= word_left_d;
      xr_q        <= xr_d;
      xi_q        <= xi_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign xr      = xr_q;
  assign xi      = xi_q;
  assign valid_o = valid_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_comm_map_framer.sv
// Directed bench for comm_map_framer with default parameters.
module tb_comm_map_framer;

  localparam int DIN_W = 128;
  localparam int WIDTH = 11;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b0;
  logic                    rd_en;
  logic [DIN_W-1:0]        din = '0;
  logic                    empty = 1'b1;
  logic                    mode = 1'b0;
  logic                    ready_i = 1'b1;
  logic signed [WIDTH-1:0] xr, xi;
  logic                    valid_o, sof, eof, busy;

  comm_map_framer #(
    .DIN_W (DIN_W), .FFT_N (64), .WIDTH (WIDTH), .AMP (256)
  ) dut (
    .CLK (CLK), .RST (RST), .rd_en (rd_en), .din (din), .empty (empty),
    .mode (mode), .ready_i (ready_i), .xr (xr), .xi (xi), .valid_o (valid_o),
    .sof (sof), .eof (eof), .busy (busy)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  logic pop_now = 1'b0;
  logic ready_nxt = 1'b1;
  logic [DIN_W-1:0] fifo_d[$];
  logic             fifo_m[$];
  int xr_log[$], xi_log[$], val_cyc[$], rd_cyc[$];
  int sof_idx[$], eof_idx[$], sof_cyc[$], eof_cyc[$];
  int r, cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    xr_log.delete(); xi_log.delete(); val_cyc.delete(); rd_cyc.delete();
    sof_idx.delete(); eof_idx.delete(); sof_cyc.delete(); eof_cyc.delete();
  endtask

  task automatic push(input logic [DIN_W-1:0] w, input logic m);
    fifo_d.push_back(w);
    fifo_m.push_back(m);
  endtask

  // one clock: update FIFO model and inputs after the edge, sample mid-cycle
  task automatic cycle();
    @(posedge CLK); #1;
    if (pop_now) begin
      void'(fifo_d.pop_front());
      void'(fifo_m.pop_front());
    end
    pop_now = 1'b0;
    ready_i = ready_nxt;
    empty   = (fifo_d.size() == 0);
    din     = empty ? '0 : fifo_d[0];
    mode    = empty ? 1'b0 : fifo_m[0];
    @(negedge CLK);
    cyc_n++;
    if (rd_en) begin
      pop_now = 1'b1;
      rd_cyc.push_back(cyc_n);
    end
    if (valid_o) begin
      if (sof) begin sof_idx.push_back(xr_log.size()); sof_cyc.push_back(cyc_n); end
      if (eof) begin eof_idx.push_back(xr_log.size()); eof_cyc.push_back(cyc_n); end
      xr_log.push_back(int'(xr));
      xi_log.push_back(int'(xi));
      val_cyc.push_back(cyc_n);
    end
  endtask

  initial begin
    // reset state
    repeat (2) cycle();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sof", int'(sof), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xr", int'(xr), 0);
    chk("rst_xi", int'(xi), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    RST = 1'b1;
    repeat (2) cycle();

    // BPSK, single word with only bit0 set
    clear_logs();
    push(128'h1, 1'b0);
    repeat (140) cycle();
    chk("t1_rd_cnt", rd_cyc.size(), 1);
    chk("t1_nvalid", xr_log.size(), 128);
    chk("t1_latency", qget(val_cyc, 0), qget(rd_cyc, 0) + 1);
    chk("t1_gapless", qget(val_cyc, 127) - qget(val_cyc, 0), 127);
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("t1_xr[%0d]", i), qget(xr_log, i), (i == 0) ? 256 : -256);
      chk($sformatf("t1_xi[%0d]", i), qget(xi_log, i), 0);
    end
    chk("t1_nsof", sof_idx.size(), 2);
    chk("t1_sof0", qget(sof_idx, 0), 0);
    chk("t1_sof1", qget(sof_idx, 1), 64);
    chk("t1_neof", eof_idx.size(), 2);
    chk("t1_eof0", qget(eof_idx, 0), 63);
    chk("t1_eof1", qget(eof_idx, 1), 127);
    chk("t1_busy_end", int'(busy), 0);

    // QPSK, LSBs 2'b10
    clear_logs();
    push(128'h2, 1'b1);
    repeat (75) cycle();
    chk("t2_nvalid", xr_log.size(), 64);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("t2_xr[%0d]", i), qget(xr_log, i), -256);
      chk($sformatf("t2_xi[%0d]", i), qget(xi_log, i), (i == 0) ? 256 : -256);
    end
    chk("t2_nsof", sof_idx.size(), 1);
    chk("t2_neof", eof_idx.size(), 1);
    chk("t2_eof_idx", qget(eof_idx, 0), 63);
    chk("t2_busy_end", int'(busy), 0);

    // back-to-back words, modes BPSK/QPSK/BPSK
    clear_logs();
    push(128'h1, 1'b0);
    push(128'h3, 1'b1);
    push(128'h0, 1'b0);
    repeat (335) cycle();
    chk("t3_rd_cnt", rd_cyc.size(), 3);
    chk("t3_nvalid", xr_log.size(), 320);
    chk("t3_gapless", qget(val_cyc, 319) - qget(val_cyc, 0), 319);
    chk("t3_rd1_at_eof", qget(rd_cyc, 1), qget(eof_cyc, 1));
    chk("t3_rd2_at_eof", qget(rd_cyc, 2), qget(eof_cyc, 2));
    chk("t3_nsof", sof_idx.size(), 5);
    for (int i = 0; i < 320; i++) begin
      int ex, ey;
      if (i < 128) begin
        ex = (i == 0) ? 256 : -256; ey = 0;
      end else if (i < 192) begin
        ex = (i == 128) ? 256 : -256; ey = ex;
      end else begin
        ex = -256; ey = 0;
      end
      chk($sformatf("t3_xr[%0d]", i), qget(xr_log, i), ex);
      chk($sformatf("t3_xi[%0d]", i), qget(xi_log, i), ey);
    end

    // backpressure between frames of one BPSK word
    clear_logs();
    push(128'h0, 1'b0);
    cycle();
    r = cyc_n;
    chk("t4_rd_first", qget(rd_cyc, 0), r);
    for (int k = 1; k <= 175; k++) begin
      ready_nxt = (k >= 10 && k < 100) ? 1'b0 : 1'b1;
      cycle();
      if (k == 80) begin
        chk("t4_hold_busy", int'(busy), 1);
        chk("t4_hold_valid", int'(valid_o), 0);
      end
    end
    ready_nxt = 1'b1;
    chk("t4_rd_cnt", rd_cyc.size(), 1);
    chk("t4_nvalid", xr_log.size(), 128);
    chk("t4_sof0_cyc", qget(sof_cyc, 0), r + 1);
    chk("t4_eof0_cyc", qget(eof_cyc, 0), r + 64);
    chk("t4_sof1_cyc", qget(sof_cyc, 1), r + 101);
    chk("t4_eof1_cyc", qget(eof_cyc, 1), r + 164);
    cnt = 0;
    foreach (val_cyc[i]) if (val_cyc[i] > r + 64 && val_cyc[i] < r + 101) cnt++;
    chk("t4_gap_valid", cnt, 0);

    // FIFO empty at word end, refill ten cycles later
    clear_logs();
    push(128'h0, 1'b1);
    cycle();
    r = cyc_n;
    repeat (64) cycle();
    chk("t5_eof_cyc", qget(eof_cyc, 0), r + 64);
    cycle();
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_valid", int'(valid_o), 0);
    repeat (9) cycle();
    chk("t5_no_rd_empty", rd_cyc.size(), 1);
    push(128'h1, 1'b0);
    cycle();
    chk("t5_rd_refill", qget(rd_cyc, 1), cyc_n);
    cycle();
    chk("t5_sof_after", int'(sof && valid_o), 1);
    chk("t5_xr_after", int'(xr), 256);
    repeat (140) cycle();

    // reset in the middle of a frame
    clear_logs();
    push(128'h1, 1'b0);
    cycle();
    repeat (31) cycle();
    chk("t6_pre_nvalid", xr_log.size(), 31);
    chk("t6_pre_valid", int'(valid_o), 1);
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_valid", int'(valid_o), 0);
    chk("t6_rst_sof", int'(sof), 0);
    chk("t6_rst_eof", int'(eof), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_xr", int'(xr), 0);
    repeat (3) cycle();
    RST = 1'b1;
    clear_logs();
    repeat (20) cycle();
    chk("t6_post_nvalid", xr_log.size(), 0);
    chk("t6_post_busy", int'(busy), 0);
    chk("t6_post_rd", rd_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comm_map_framer.md
Name: comm_map_framer

Overview:
- Parametrised successor to the fixed BPSK mapping stage of the transmit chain.
- Pops DIN_W-bit words from a first-word-fall-through FIFO and maps them to signed I/Q samples, BPSK or QPSK selected per word at run time.
- Emits gapless FFT_N-sample frames with start/end-of-frame markers, directly feeding the IFFT input FIFO.
- Honours a frame-granular downstream ready, so the IFFT never receives a partial frame.

Parameters:
- DIN_W, 128, input word width; must equal k*FFT_N*2 for integer k >= 1.
- FFT_N, 64, samples per frame, power of two.
- WIDTH, 11, signed sample width of xr/xi.
- AMP, 256, constellation magnitude; must satisfy 0 < AMP < 2^(WIDTH-1).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- rd_en  out  1  FIFO pop, combinational, asserted in the cycle din is captured.
- din  in  DIN_W  FIFO head word, valid while empty=0.
- empty  in  1  FIFO empty.
- mode  in  1  0=BPSK, 1=QPSK; sampled only when a word is captured.
- ready_i  in  1  downstream can accept a whole frame; sampled only at frame start.
- xr  out  WIDTH  signed I sample.
- xi  out  WIDTH  signed Q sample.
- valid_o  out  1  sample valid.
- sof  out  1  first sample of frame, qualified by valid_o.
- eof  out  1  last sample of frame, qualified by valid_o.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - State to IDLE.
  - valid_o, sof, eof, busy = 0; xr, xi = 0.
  - Shift register and counters cleared.
  - A word already popped is discarded. Reset mid-frame truncates the frame; no further samples appear.
- States: IDLE, RUN, HOLD.
- Word capture condition ("load"): !empty && ready_i, in IDLE, in HOLD at a word boundary, or in RUN on the last sample of a word.
  - On load: rd_en=1 that cycle; din goes to the shift register; mode is latched into mode_q.
  - Samples per word: DIN_W for BPSK, DIN_W/2 for QPSK. Frames per word: DIN_W/FFT_N (BPSK) or DIN_W/(2*FFT_N) (QPSK).
- Latency: load in cycle t -> first valid_o in cycle t+1. Outputs are registered.
- RUN: one sample per cycle, valid_o=1 continuously; samp_cnt counts 0..FFT_N-1.
  - sof when samp_cnt==0; eof when samp_cnt==FFT_N-1.
- Mapping (bits consumed LSB first):
  - BPSK: bit b -> xr = b ? +AMP : -AMP; xi = 0.
  - QPSK: pair (b[2k], b[2k+1]) -> xr = b[2k] ? +AMP : -AMP; xi = b[2k+1] ? +AMP : -AMP.
  - Two's complement, exact; no saturation is needed given the AMP constraint.
- At eof, word not exhausted:
  - ready_i=1 -> next frame starts the following cycle, no gap.
  - ready_i=0 -> HOLD with valid_o=0; the next frame resumes the cycle after ready_i is seen high.
- At eof, word exhausted:
  - Load condition true -> new word captured in the same cycle; next frame is gapless, in the newly latched mode.
  - Otherwise, !ready_i && !empty -> HOLD at word boundary.
  - Otherwise -> IDLE.
- HOLD at word boundary with empty=1 and ready_i=1 -> IDLE.
- Mode changes between loads are ignored; mode never changes inside a word.
- rd_en is never asserted while empty=1, nor more than once per word.
- Simultaneous eof, empty falling and ready_i high: load wins and the stream stays gapless.

Decomposition:
- Package comm_pkg:
  - MODE_BPSK=0, MODE_QPSK=1.
  - State encoding for IDLE/RUN/HOLD.
  - Function for log2 of FFT_N.
- Sub-module iq_symbol_map: combinational mapper taking (mode_q, two LSBs of the shift register) and returning (xr, xi) with AMP/WIDTH parameters. It is reused by a later 16-QAM extension.
- Counters, FSM and shift register stay in comm_map_framer.

Test Plan:
- BPSK, defaults, one word 0x...0001 (only bit0 set), ready_i=1 -> rd_en pulse once; 128 valid cycles; sample0 xr=+256, samples 1..127 xr=-256; xi=0 throughout; sof at samples 0 and 64; eof at 63 and 127.
- QPSK, word with LSBs 2'b10 (rest 0) -> 64 samples; sample0 xr=-256, xi=+256; others xr=xi=-256; exactly one sof/eof pair; then IDLE.
- Back-to-back: three words queued, mode toggled 0,1,0 between loads -> valid_o continuous for 128+64+128 cycles; mode follows the per-word latch; rd_en exactly 3 pulses, each coinciding with the previous word's last eof.
- Backpressure: BPSK word, ready_i dropped during frame 0 -> frame 0 completes all 64 samples; valid_o=0 while ready_i=0; frame 1 starts the cycle after ready_i returns high; no rd_en while held.
- Empty at word end: single word, FIFO then empty -> IDLE after eof; busy=0 the next cycle; word pushed 10 cycles later -> rd_en in the first non-empty cycle; sof one cycle after.
- Reset asserted at sample 30 of a frame -> valid_o, sof, eof, busy low immediately; no samples after release until a new load.
